// File: rtl/i2s_clk_ctrl.sv
// I2S master-mode clock controller: derives bck/lrck from clk and emits
// clk-domain sampling strobes for the receive datapath. A stop request is
// honoured only on a stereo frame boundary so no partial word is delivered.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | clocks parked low, counters cleared, waiting for enable
// S_RUN      | bck/lrck running, strobes generated
// S_STOPPING | still running, leaves at the falling edge closing the frame
module i2s_clk_ctrl #(
    parameter int BCK_DIV  = 2,
    parameter int NUM_BITS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    output logic                        bck,
    output logic                        lrck,
    output logic                        busy,
    output logic                        bit_strobe,
    output logic [$clog2(NUM_BITS)-1:0] bit_idx,
    output logic                        word_done,
    output logic                        word_ch
);

    localparam int HALF = BCK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int SW   = $clog2(NUM_BITS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [SW-1:0]   bit_idx_q, bit_idx_d;
    logic            bck_q, bck_d;
    logic            lrck_q, lrck_d;
    logic            first_q, first_d;
    logic            bit_strobe_q, bit_strobe_d;
    logic            word_done_q, word_done_d;
    logic            word_ch_q, word_ch_d;

    logic            running;
    logic            tc;
    logic            rise_ev;
    logic            fall_ev;
    logic            frame_end;

    // Divider terminal count and the bck edge events it produces.
    always_comb begin
        running   = (state_q != S_IDLE);
        tc        = running && (div_cnt_q == DW'(HALF - 1));
        rise_ev   = tc && !bck_q;
        fall_ev   = tc && bck_q;
        // Falling edge closing slot 0 of the left half: the right word's LSB
        // (or nothing, before the first data bit) has just been strobed.
        frame_end = fall_ev && (slot_q == '0) && !lrck_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            slot_q       <= '0;
            bit_idx_q    <= '0;
            bck_q        <= 1'b0;
            lrck_q       <= 1'b0;
            first_q      <= 1'b0;
            bit_strobe_q <= 1'b0;
            word_done_q  <= 1'b0;
            word_ch_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            slot_q       <= slot_d;
            bit_idx_q    <= bit_idx_d;
            bck_q        <= bck_d;
            lrck_q       <= lrck_d;
            first_q      <= first_d;
            bit_strobe_q <= bit_strobe_d;
            word_done_q  <= word_done_d;
            word_ch_q    <= word_ch_d;
        end
    end

    // Next-state: a re-request while stopping wins over the frame-end exit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (enable) state_d = S_RUN;
            S_RUN:      if (!enable) state_d = S_STOPPING;
            S_STOPPING: begin
                if (enable)         state_d = S_RUN;
                else if (frame_end) state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // Divider, slot counter and strobe generation.
    always_comb begin
        div_cnt_d    = div_cnt_q;
        slot_d       = slot_q;
        bit_idx_d    = bit_idx_q;
        bck_d        = bck_q;
        lrck_d       = lrck_q;
        first_d      = first_q;
        bit_strobe_d = 1'b0;
        word_done_d  = 1'b0;
        word_ch_d    = word_ch_q;
        if (state_q == S_IDLE || state_d == S_IDLE) begin
            div_cnt_d = '0;
            slot_d    = '0;
            bck_d     = 1'b0;
            lrck_d    = 1'b0;
            first_d   = 1'b1;
        end else begin
            div_cnt_d = tc ? '0 : div_cnt_q + DW'(1);
            if (rise_ev) begin
                bck_d = 1'b1;
                if (slot_q != '0 || !first_q) begin
                    bit_strobe_d = 1'b1;
                    bit_idx_d    = (slot_q == '0) ? '0 : SW'(NUM_BITS - int'(slot_q));
                end
                // Slot 0 carries the previous channel's LSB (one-bck delay).
                if (slot_q == '0 && !first_q) begin
                    word_done_d = 1'b1;
                    word_ch_d   = !lrck_q;
                end
            end
            if (fall_ev) begin
                bck_d   = 1'b0;
                first_d = 1'b0;
                if (slot_q == SW'(NUM_BITS - 1)) begin
                    slot_d = '0;
                    lrck_d = !lrck_q;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
        end
    end

    // Outputs straight from registers.
    always_comb begin
        bck        = bck_q;
        lrck       = lrck_q;
        busy       = running;
        bit_strobe = bit_strobe_q;
        bit_idx    = bit_idx_q;
        word_done  = word_done_q;
        word_ch    = word_ch_q;
    end

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Bench for i2s_clk_ctrl: two instances (BCK_DIV=2/NUM_BITS=16 and
// BCK_DIV=6/NUM_BITS=24) share randomized enable/reset stimulus. A reference
// model derives every bck/lrck level and strobe from elapsed time since run
// start; expected strobes go into per-instance queues consumed by a monitor.
module tb_i2s_clk_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    always #5 clk = ~clk;

    logic       bck0, lrck0, busy0, bs0, wd0, ch0;
    logic [3:0] idx0;
    logic       bck1, lrck1, busy1, bs1, wd1, ch1;
    logic [4:0] idx1;

    i2s_clk_ctrl #(.BCK_DIV(2), .NUM_BITS(16)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable),
        .bck(bck0), .lrck(lrck0), .busy(busy0), .bit_strobe(bs0),
        .bit_idx(idx0), .word_done(wd0), .word_ch(ch0)
    );

    i2s_clk_ctrl #(.BCK_DIV(6), .NUM_BITS(24)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable),
        .bck(bck1), .lrck(lrck1), .busy(busy1), .bit_strobe(bs1),
        .bit_idx(idx1), .word_done(wd1), .word_ch(ch1)
    );

    typedef struct {
        int cyc;
        int idx;
        bit wd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int H[2] = '{1, 3};
    int N[2] = '{16, 24};

    bit active[2];
    bit stopping[2];
    int t0[2];
    bit e_bck[2];
    bit e_lrck[2];
    bit e_ch[2];
    int words[2];

    task automatic model_step(input int i);
        int   rel, m, k, h, n;
        bit   was_stop;
        exp_t e;
        h = H[i];
        n = N[i];
        if (reset) begin
            active[i]   = 1'b0;
            stopping[i] = 1'b0;
            e_bck[i]    = 1'b0;
            e_lrck[i]   = 1'b0;
            e_ch[i]     = 1'b0;
            return;
        end
        if (!active[i]) begin
            if (enable) begin
                active[i]   = 1'b1;
                stopping[i] = 1'b0;
                t0[i]       = cyc;
            end
            e_bck[i]  = 1'b0;
            e_lrck[i] = 1'b0;
            return;
        end
        rel         = cyc - t0[i];
        was_stop    = stopping[i];
        stopping[i] = !enable;
        if (rel % h == 0) begin
            m = rel / h;
            if (m % 2 == 1) begin
                // rising edge number k; global bit slot k of the session
                k = (m - 1) / 2;
                if (k > 0) begin
                    e.cyc = cyc;
                    e.idx = (k % n == 0) ? 0 : n - (k % n);
                    e.wd  = (k % n == 0);
                    if (e.wd) begin
                        e_ch[i] = ((k / n) % 2 == 0);
                        words[i]++;
                    end
                    if (i == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end else begin
                k = (m - 2) / 2;
                if (was_stop && !enable && (k % (2 * n) == 0)) begin
                    active[i]   = 1'b0;
                    stopping[i] = 1'b0;
                    e_bck[i]    = 1'b0;
                    e_lrck[i]   = 1'b0;
                    return;
                end
            end
        end
        e_bck[i]  = ((rel / h) % 2 == 1);
        e_lrck[i] = (((rel / (2 * h)) / n) % 2 == 1);
    endtask

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst%0d cyc=%0d actual=%0d expected=%0d", name, i, cyc, act, exp);
        end
    endtask

    task automatic check_step(input int i);
        logic bs, wd, ch, bk, lr, by;
        int   idx;
        bit   have;
        exp_t e;
        if (i == 0) begin
            bs = bs0; wd = wd0; ch = ch0; bk = bck0; lr = lrck0; by = busy0; idx = int'(idx0);
            have = (q0.size() > 0) && (q0[0].cyc == cyc);
            if (have) e = q0.pop_front();
        end else begin
            bs = bs1; wd = wd1; ch = ch1; bk = bck1; lr = lrck1; by = busy1; idx = int'(idx1);
            have = (q1.size() > 0) && (q1[0].cyc == cyc);
            if (have) e = q1.pop_front();
        end
        chk("bck", i, int'(bk), int'(e_bck[i]));
        chk("lrck", i, int'(lr), int'(e_lrck[i]));
        chk("busy", i, int'(by), int'(active[i]));
        chk("word_ch", i, int'(ch), int'(e_ch[i]));
        if (bs) begin
            if (!have) begin
                chk("unexpected_strobe", i, 1, 0);
            end else begin
                chk("bit_idx", i, idx, e.idx);
                chk("word_done", i, int'(wd), int'(e.wd));
            end
        end else if (have) begin
            chk("missing_strobe", i, 0, 1);
        end else begin
            chk("word_done_no_strobe", i, int'(wd), 0);
        end
    endtask

    // Reference model advances on every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // Monitor samples DUT outputs on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) check_step(i);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int r;
        reset  = 1'b1;
        enable = 1'b0;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        enable = 1'b1;
        wait_cyc(200);
        // mid-left-word stop, allowed to drain completely
        enable = 1'b0;
        wait_cyc(700);
        enable = 1'b1;
        wait_cyc(100);
        // brief drop: re-request while stopping
        enable = 1'b0;
        wait_cyc(5);
        enable = 1'b1;
        wait_cyc(150);
        // reset in the middle of a running frame
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        wait_cyc(300);
        for (int it = 0; it < 14; it++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0: begin
                    enable = 1'b0;
                    wait_cyc(int'($urandom_range(1, 700)));
                    enable = 1'b1;
                end
                1: begin
                    enable = 1'b0;
                    wait_cyc(int'($urandom_range(1, 30)));
                    enable = 1'b1;
                end
                2: begin
                    reset = 1'b1;
                    wait_cyc(int'($urandom_range(1, 3)));
                    reset = 1'b0;
                end
                default: wait_cyc(int'($urandom_range(1, 50)));
            endcase
            wait_cyc(int'($urandom_range(10, 400)));
        end
        enable = 1'b0;
        wait_cyc(800);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
